// File: rtl/aes128_coprocessor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : aes128_coprocessor                                       |
// | Brief   : Iterative AES-128 encryptor. One round per clock, key    |
// |           schedule expanded on the fly, start/busy/done handshake. |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module aes128_coprocessor (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ptext,
  input  logic [127:0] key,
  output logic [127:0] ctext_aes,
  output logic         busy,
  output logic         done
);

  // Controller states: idle after reset, running rounds, result held
  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [3:0] c_last_round = 4'd10;

  // AES S-box, byte 0x00 in the most significant position
  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b sits at bit 8*(255-b)+7, which is simply {~b, 3'b111}
  function automatic logic [7:0] f_sbox(input logic [7:0] b);
    return c_sbox[{~b, 3'b111} -: 8];
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11b
  function automatic logic [7:0] f_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]   r_fsm;
  logic [1:0]   w_fsm_next;
  logic [3:0]   r_round;
  logic [127:0] r_state;
  logic [127:0] r_rkey;
  logic         w_load;
  logic         w_step;
  logic         w_last;
  logic [7:0]   w_rcon;
  logic [31:0]  w_sub_rot;
  logic [127:0] w_next_key;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_round_out;

  // ------------------------------------------------------------------
  // Round datapath
  // ------------------------------------------------------------------

  // SubBytes merged with ShiftRows: row r of column c takes column (c+r)%4
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[127-8*(4*c+r) -: 8] = f_sbox(r_state[127-8*(4*((c+r)%4)+r) -: 8]);
    end
  end

  // MixColumns on each column of the shifted state
  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] w_a0;
    logic [7:0] w_a1;
    logic [7:0] w_a2;
    logic [7:0] w_a3;
    assign w_a0 = w_sr[127-32*c -: 8];
    assign w_a1 = w_sr[119-32*c -: 8];
    assign w_a2 = w_sr[111-32*c -: 8];
    assign w_a3 = w_sr[103-32*c -: 8];
    assign w_mc[127-32*c -: 8] = f_xtime(w_a0) ^ f_xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign w_mc[119-32*c -: 8] = w_a0 ^ f_xtime(w_a1) ^ f_xtime(w_a2) ^ w_a2 ^ w_a3;
    assign w_mc[111-32*c -: 8] = w_a0 ^ w_a1 ^ f_xtime(w_a2) ^ f_xtime(w_a3) ^ w_a3;
    assign w_mc[103-32*c -: 8] = f_xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ f_xtime(w_a3);
  end

  // Round constant for the round key being produced this cycle
  always_comb begin
    w_rcon = 8'h00;
    case (r_round)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // SubWord(RotWord(w3)): rotate bytes left by one, then substitute
  assign w_sub_rot = {f_sbox(r_rkey[23:16]), f_sbox(r_rkey[15:8]),
                      f_sbox(r_rkey[7:0]),   f_sbox(r_rkey[31:24])};

  assign w_next_key[127:96] = r_rkey[127:96] ^ w_sub_rot ^ {w_rcon, 24'h000000};
  assign w_next_key[95:64]  = r_rkey[95:64]  ^ w_next_key[127:96];
  assign w_next_key[63:32]  = r_rkey[63:32]  ^ w_next_key[95:64];
  assign w_next_key[31:0]   = r_rkey[31:0]   ^ w_next_key[63:32];

  assign w_last      = (r_round == c_last_round);
  assign w_round_out = (w_last ? w_sr : w_mc) ^ w_next_key;

  // ------------------------------------------------------------------
  // Controller
  // ------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= c_idle;
    else     r_fsm <= w_fsm_next;
  end

  // Next-state: accept from idle/done, leave run after the final round
  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      c_idle:  if (start)  w_fsm_next = c_run;
      c_run:   if (w_last) w_fsm_next = c_done;
      c_done:  if (start)  w_fsm_next = c_run;
      default: w_fsm_next = c_idle;
    endcase
  end

  // Outputs and datapath enables decoded from the current state
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_fsm)
      c_idle: w_load = start;
      c_run: begin
        w_step = 1'b1;
        busy   = 1'b1;
      end
      c_done: begin
        w_load = start;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers: load block, step one round, latch final result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= '0;
      r_rkey    <= '0;
      r_round   <= '0;
      ctext_aes <= '0;
    end else if (w_load) begin
      r_state <= ptext ^ key;
      r_rkey  <= key;
      r_round <= 4'd1;
    end else if (w_step) begin
      r_state <= w_round_out;
      r_rkey  <= w_next_key;
      if (w_last) begin
        ctext_aes <= w_round_out;
        r_round   <= 4'd0;
      end else begin
        r_round <= r_round + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes128_coprocessor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_aes128_coprocessor                                    |
// | Brief   : Self-checking bench for aes128_coprocessor against a     |
// |           behavioural AES-128 model and FIPS-197 vectors.          |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_aes128_coprocessor;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] ptext;
  logic [127:0] key;
  logic [127:0] ctext_aes;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] c_b_pt  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] c_b_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_b_ct  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] c_c_pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_c_key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_c_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] c_z_ct  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_coprocessor dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ptext     (ptext),
    .key       (key),
    .ctext_aes (ctext_aes),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   st [4][4];
    logic [7:0]   t  [4][4];
    logic [31:0]  w  [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_tab[st[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rd < 10) begin
          st[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
          st[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
          st[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
          st[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
        end else begin
          for (int r = 0; r < 4; r++) st[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ w[4*rd+c][31-8*r -: 8];
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = st[r][c];
    return res;
  endfunction

  // Cycle-level expectation: block captured when idle, result 10 edges later
  logic         m_busy;
  logic         m_done;
  logic [127:0] m_ct;
  logic [127:0] m_res;
  int           m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_ct   = '0;
      m_cnt  = 0;
    end else if (m_busy) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == 10) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_ct   = m_res;
      end
    end else if (start) begin
      m_res  = aes_model(ptext, key);
      m_busy = 1'b1;
      m_done = 1'b0;
      m_cnt  = 0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(posedge clk) begin
    #1;
    chk("cyc_busy", 128'(busy), 128'(m_busy));
    chk("cyc_done", 128'(done), 128'(m_done));
    chk("cyc_ctext", ctext_aes, m_ct);
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic run_vec(input string name, input logic [127:0] pt, input logic [127:0] k,
                         input logic [127:0] exp_ct);
    int n;
    @(negedge clk);
    ptext = pt;
    key   = k;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk({name, "_latency"}, 128'(n), 128'(10));
    chk({name, "_ct"}, ctext_aes, exp_ct);
    chk({name, "_busy"}, 128'(busy), 128'(0));
  endtask

  task automatic rand_inputs();
    ptext = {$urandom, $urandom, $urandom, $urandom};
    key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    int n1;
    int n2;
    start = 1'b0;
    ptext = '0;
    key   = '0;
    rst   = 1'b0;
    build_sbox();
    #1 rst = 1'b1;

    chk("model_sbox00", 128'(sbox_tab[8'h00]), 128'(8'h63));
    chk("model_sbox53", 128'(sbox_tab[8'h53]), 128'(8'hed));
    chk("model_vecB", aes_model(c_b_pt, c_b_key), c_b_ct);
    chk("model_vecC", aes_model(c_c_pt, c_c_key), c_c_ct);
    chk("model_zero", aes_model('0, '0), c_z_ct);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctext", ctext_aes, 128'h0);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("idle_out", {ctext_aes[125:0], busy, done}, 128'h0);
    end

    run_vec("vecB", c_b_pt, c_b_key, c_b_ct);
    repeat (3) @(posedge clk);
    run_vec("vecC", c_c_pt, c_c_key, c_c_ct);
    run_vec("zero", '0, '0, c_z_ct);

    // Back-to-back with start held high and inputs churning while busy
    @(negedge clk);
    ptext = c_b_pt;
    key   = c_b_key;
    start = 1'b1;
    @(posedge clk);
    n1 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      rand_inputs();
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        n1 = i;
        break;
      end
    end
    chk("b2b_lat1", 128'(n1), 128'(10));
    chk("b2b_ct1", ctext_aes, c_b_ct);
    @(negedge clk);
    ptext = c_c_pt;
    key   = c_c_key;
    @(posedge clk);
    #1;
    chk("b2b_accept_done", 128'(done), 128'(0));
    chk("b2b_accept_busy", 128'(busy), 128'(1));
    chk("b2b_hold_ct", ctext_aes, c_b_ct);
    n2 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      rand_inputs();
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        n2 = i;
        break;
      end
    end
    chk("b2b_lat2", 128'(n2), 128'(10));
    chk("b2b_ct2", ctext_aes, c_c_ct);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);

    // Reset in the middle of a run
    @(negedge clk);
    ptext = c_b_pt;
    key   = c_b_key;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ctext", ctext_aes, 128'h0);
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_done", 128'(done), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    run_vec("postrst_vecB", c_b_pt, c_b_key, c_b_ct);

    // Randomized blocks with stray start pulses while busy
    for (int b = 0; b < 25; b++) begin
      @(negedge clk);
      rand_inputs();
      start = 1'b1;
      @(posedge clk);
      n1 = -1;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        rand_inputs();
        start = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
          n1 = i;
          break;
        end
      end
      chk("rand_lat", 128'(n1), 128'(10));
      @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/aes128_coprocessor.md
Name: aes128_coprocessor

Overview:
Iterative AES-128 encryption engine (FIPS-197, encrypt only) for use as a memory-mapped or streaming crypto coprocessor. It accepts a 128-bit plaintext block and a 128-bit cipher key and returns the 128-bit ciphertext. It computes one AES round per clock and expands the key schedule on the fly, with a start/busy/done handshake.

Parameters:
None. Key size is fixed at 128 bits and the round count is fixed at 10.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request to encrypt; sampled on the rising edge of clk
ptext  input  128  plaintext; bits [127:120] are FIPS-197 byte in0
key  input  128  cipher key; bits [127:120] are FIPS-197 byte k0
ctext_aes  output  128  ciphertext; bits [127:120] are FIPS-197 byte out0
busy  output  1  high while an encryption is in progress
done  output  1  high when ctext_aes holds a valid result

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- While rst is high:
  - ctext_aes = 0, busy = 0, done = 0.
  - Round counter = 0; internal state and round-key registers = 0.
- Byte order: state is column-major per FIPS-197. ptext[127:96] is column 0, and so on down to ptext[31:0] as column 3. The same mapping applies to key and ctext_aes.
- Accept: the engine captures ptext and key on a rising edge where start = 1 and busy = 0 (edge E0). On that edge:
  - state <= ptext XOR key (initial AddRoundKey).
  - round-key register <= key.
  - round = 1, busy <= 1, done <= 0.
- Rounds 1-9, one per edge E1..E9:
  - Next round key is derived from the current round key by the standard schedule: RotWord, SubWord, XOR Rcon.
  - Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), next round key).
  - round-key register <= next round key; round increments.
- Final round, edge E10:
  - Same as rounds 1-9 but MixColumns is skipped.
  - ctext_aes <= result, busy <= 0, done <= 1.
- Latency: done and a valid ctext_aes are visible starting 10 edges after the accept edge. Throughput is one block per 11 cycles, since start can be accepted on the edge after done rises.
- Inputs are ignored after capture: ptext and key may change freely while busy = 1.
- start while busy = 1 is ignored; no queuing and no abort.
- done is a level, not a pulse:
  - It stays high and ctext_aes holds its value until the next accepted start.
  - On that accept edge, done clears; ctext_aes keeps its old value until the new result is written at E10.
- start held high continuously re-triggers on the first edge where busy = 0.
- rst asserted mid-operation aborts immediately to the reset values. No partial result is ever flagged done.
- Datapath arithmetic:
  - SubBytes uses the standard AES S-box: 16 instances for the state and 4 for the key schedule. Purely combinational.
  - MixColumns uses GF(2^8) arithmetic with xtime reduction polynomial 0x11b.
- There are no X outputs in any state after reset.

Test Plan:
- FIPS-197 Appendix B: ptext = 3243f6a8885a308d313198a2e0370734, key = 2b7e151628aed2a6abf7158809cf4f3c, pulse start -> done = 1 exactly 10 edges after the accept edge, ctext_aes = 3925841d02dc09fbdc118597196a0b32, busy = 0.
- FIPS-197 Appendix C.1: ptext = 00112233445566778899aabbccddeeff, key = 000102030405060708090a0b0c0d0e0f -> ctext_aes = 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero ptext and key -> ctext_aes = 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Back-to-back blocks with start held high and inputs changed mid-operation:
  - First result is unaffected by the input changes.
  - The second start is accepted on the edge after done rises.
  - Both ciphertexts match their vectors; start pulses during busy are ignored.
- Reset behaviour:
  - Assert rst at E5 of a run -> outputs immediately 0, busy = 0, done = 0.
  - After release, a fresh Appendix B run produces 3925841d02dc09fbdc118597196a0b32.
- Post-reset idle with start = 0 for 20 cycles -> done = 0, busy = 0, ctext_aes = 0 throughout.
